// File: rtl/vga_pixel_out.sv
// ============================================================================
// vga_pixel_out: VGA timing generator and pixel output stage that pops RGB
// words from a show-ahead FIFO, one per active pixel, once the FIFO has filled.
// Revision: 1.0
// ============================================================================
`default_nettype none

module vga_pixel_out #(
    parameter int HDISP  = 800,
    parameter int VDISP  = 480,
    parameter int HFP    = 40,
    parameter int HPULSE = 48,
    parameter int HBP    = 40,
    parameter int VFP    = 13,
    parameter int VPULSE = 3,
    parameter int VBP    = 29
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [23:0] fifo_rdata,
    input  logic        fifo_rempty,
    input  logic        fifo_wfull,
    output logic        fifo_rreq,
    output logic        vga_clk,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank,
    output logic        vga_sync,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        underflow
);

    localparam int HTOTAL = HFP + HPULSE + HBP + HDISP;
    localparam int VTOTAL = VFP + VPULSE + VBP + VDISP;
    localparam int HW     = $clog2(HTOTAL);
    localparam int VW     = $clog2(VTOTAL);

    localparam logic [HW-1:0] H_SYNC_BEG = HW'(HFP);
    localparam logic [HW-1:0] H_SYNC_END = HW'(HFP + HPULSE);
    localparam logic [HW-1:0] H_ACT_BEG  = HW'(HFP + HPULSE + HBP);
    localparam logic [HW-1:0] H_LAST     = HW'(HTOTAL - 1);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(VFP);
    localparam logic [VW-1:0] V_SYNC_END = VW'(VFP + VPULSE);
    localparam logic [VW-1:0] V_ACT_BEG  = VW'(VFP + VPULSE + VBP);
    localparam logic [VW-1:0] V_LAST     = VW'(VTOTAL - 1);

    typedef enum logic [0:0] {
        WAIT_FILL = 1'b0,
        RUN       = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic          running;
    logic          active;
    logic          h_sync_zone;
    logic          v_sync_zone;
    logic          h_last;
    logic          v_last;

    // Once started the display free-runs; only reset returns to WAIT_FILL.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= WAIT_FILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            WAIT_FILL: if (fifo_wfull) state_next = RUN;
            RUN:       state_next = RUN;
            default:   state_next = WAIT_FILL;
        endcase
    end

    assign running     = (state == RUN);
    assign h_last      = (hcnt == H_LAST);
    assign v_last      = (vcnt == V_LAST);
    assign h_sync_zone = (hcnt >= H_SYNC_BEG) && (hcnt < H_SYNC_END);
    assign v_sync_zone = (vcnt >= V_SYNC_BEG) && (vcnt < V_SYNC_END);
    assign active      = (hcnt >= H_ACT_BEG) && (vcnt >= V_ACT_BEG);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (running) begin
            if (h_last) begin
                hcnt <= '0;
                vcnt <= v_last ? '0 : vcnt + 1'b1;
            end else begin
                hcnt <= hcnt + 1'b1;
            end
        end
    end

    assign fifo_rreq = running && active && !fifo_rempty;

    // Registered outputs: every signal carries the same one-cycle latency from the counters.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            vga_hs    <= 1'b1;
            vga_vs    <= 1'b1;
            vga_blank <= 1'b0;
            vga_r     <= '0;
            vga_g     <= '0;
            vga_b     <= '0;
            underflow <= 1'b0;
        end else begin
            vga_hs    <= !(running && h_sync_zone);
            vga_vs    <= !(running && v_sync_zone);
            vga_blank <= running && active;
            if (fifo_rreq) begin
                {vga_r, vga_g, vga_b} <= fifo_rdata;
            end else begin
                {vga_r, vga_g, vga_b} <= '0;
            end
            if (running && active && fifo_rempty) begin
                underflow <= 1'b1;
            end
        end
    end

    assign vga_clk  = ~clk;
    assign vga_sync = 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_vga_pixel_out.sv
// ============================================================================
// tb_vga_pixel_out: directed self-checking bench for vga_pixel_out on a
// reduced 160x90 panel. Revision: 1.0
// ============================================================================
`default_nettype none

module tb_vga_pixel_out;

    localparam int HDISP     = 160;
    localparam int VDISP     = 90;
    localparam int FRAME     = 288 * 135;                 // 38880 cycles
    localparam int FIRST_POP = 45 * 288 + 128;            // 13088
    localparam int UF_AT     = FRAME + 47 * 288 + 200;    // 52616
    localparam int RST_AT    = FRAME + 50 * 288 + 200;    // 53480

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [23:0] fifo_rdata;
    logic        fifo_rempty;
    logic        fifo_wfull = 1'b0;
    logic        fifo_rreq;
    logic        vga_clk, vga_hs, vga_vs, vga_blank, vga_sync, underflow;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic [23:0] rgb;

    logic        force_empty = 1'b0;
    logic [23:0] fifo_word = 24'd0;

    int checks = 0;
    int failures = 0;
    int c = 0;
    bit hs_prev, vs_prev, prev_rreq;
    logic [23:0] prev_rdata;
    int hs_fall, vs_fall, line_blank, pops_f1, first_pop;
    logic [23:0] exp_px = 24'd0;

    vga_pixel_out #(
        .HDISP(HDISP), .VDISP(VDISP), .HFP(40), .HPULSE(48), .HBP(40),
        .VFP(13), .VPULSE(3), .VBP(29)
    ) dut (
        .clk(clk), .nrst(nrst), .fifo_rdata(fifo_rdata), .fifo_rempty(fifo_rempty),
        .fifo_wfull(fifo_wfull), .fifo_rreq(fifo_rreq), .vga_clk(vga_clk),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank(vga_blank), .vga_sync(vga_sync),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Show-ahead FIFO model supplying an incrementing pattern.
    assign fifo_rdata  = fifo_word;
    assign fifo_rempty = force_empty;
    assign rgb         = {vga_r, vga_g, vga_b};
    always @(posedge clk) if (fifo_rreq) fifo_word <= fifo_word + 24'd1;

    task automatic test_reset();
        nrst = 1'b0;
        fifo_wfull = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (vga_hs !== 1'b1 || vga_vs !== 1'b1 || vga_blank !== 1'b0 || rgb !== 24'd0 ||
            underflow !== 1'b0 || fifo_rreq !== 1'b0 || vga_sync !== 1'b0) begin
            failures++;
            $display("FAIL reset_values hs=%b vs=%b blank=%b rgb=%h uf=%b rreq=%b sync=%b (want 1 1 0 0 0 0 0)",
                     vga_hs, vga_vs, vga_blank, rgb, underflow, fifo_rreq, vga_sync);
        end
        nrst = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (vga_hs !== 1'b1 || vga_vs !== 1'b1 || vga_blank !== 1'b0 || rgb !== 24'd0 ||
                fifo_rreq !== 1'b0 || vga_clk !== ~clk) begin
                failures++;
                $display("FAIL idle cycle=%0d hs=%b vs=%b blank=%b rgb=%h rreq=%b vclk=%b (want 1 1 0 0 0 %b)",
                         i, vga_hs, vga_vs, vga_blank, rgb, fifo_rreq, vga_clk, ~clk);
            end
        end
    endtask

    task automatic test_start();
        fifo_wfull = 1'b1;
        @(posedge clk);
        #1;
        fifo_wfull = 1'b0;
        #1;
        c = 0;
        hs_prev = 1'b1; vs_prev = 1'b1; prev_rreq = fifo_rreq; prev_rdata = fifo_rdata;
        hs_fall = -1; vs_fall = -1; line_blank = 0; pops_f1 = 0; first_pop = -1;
        checks++;
        if (vga_hs !== 1'b1 || vga_blank !== 1'b0 || fifo_rreq !== 1'b0) begin
            failures++;
            $display("FAIL start_idle hs=%b blank=%b rreq=%b (want 1 0 0)", vga_hs, vga_blank, fifo_rreq);
        end
    endtask

    // Runs the display up to cycle last_c, checking timing, data order, alignment and underflow.
    task automatic test_stream(input int last_c);
        while (c < last_c) begin
            @(posedge clk);
            #1;
            c++;
            force_empty = (c >= UF_AT) && (c < UF_AT + 5);
            #1;
            if (fifo_rreq) begin
                if (c < FRAME) pops_f1++;
                if (first_pop < 0) first_pop = c;
            end
            if (!vga_blank) begin
                checks++;
                if (rgb !== 24'd0) begin
                    failures++;
                    $display("FAIL blank_rgb c=%0d rgb=%h want 0", c, rgb);
                end
            end
            if (prev_rreq) begin
                checks++;
                if (vga_blank !== 1'b1 || rgb !== prev_rdata) begin
                    failures++;
                    $display("FAIL align c=%0d blank=%b rgb=%h want 1 %h", c, vga_blank, rgb, prev_rdata);
                end
                checks++;
                if (rgb !== exp_px) begin
                    failures++;
                    $display("FAIL order c=%0d rgb=%h want %h", c, rgb, exp_px);
                end
                exp_px = exp_px + 24'd1;
            end else if (vga_blank) begin
                checks++;
                if (rgb !== 24'd0) begin
                    failures++;
                    $display("FAIL uf_rgb c=%0d rgb=%h want 0", c, rgb);
                end
            end
            if (hs_prev && !vga_hs) begin
                checks++;
                if (hs_fall < 0 && c != 41) begin
                    failures++;
                    $display("FAIL hs_first_fall cycle=%0d want 41", c);
                end else if (hs_fall >= 0 && c - hs_fall != 288) begin
                    failures++;
                    $display("FAIL hs_period got=%0d want 288", c - hs_fall);
                end
                checks++;
                if (line_blank != 0 && line_blank != HDISP) begin
                    failures++;
                    $display("FAIL line_blank got=%0d want 0 or %0d", line_blank, HDISP);
                end
                hs_fall = c;
                line_blank = 0;
            end
            if (!hs_prev && vga_hs) begin
                checks++;
                if (c - hs_fall != 48) begin
                    failures++;
                    $display("FAIL hs_width got=%0d want 48", c - hs_fall);
                end
            end
            if (vs_prev && !vga_vs) begin
                checks++;
                if (vs_fall < 0 && c != 3745) begin
                    failures++;
                    $display("FAIL vs_first_fall cycle=%0d want 3745", c);
                end else if (vs_fall >= 0 && c - vs_fall != FRAME) begin
                    failures++;
                    $display("FAIL vs_period got=%0d want %0d", c - vs_fall, FRAME);
                end
                vs_fall = c;
            end
            if (!vs_prev && vga_vs) begin
                checks++;
                if (c - vs_fall != 864) begin
                    failures++;
                    $display("FAIL vs_width got=%0d want 864", c - vs_fall);
                end
            end
            if (vga_blank) line_blank++;
            if (c == FRAME) begin
                checks++;
                if (pops_f1 != HDISP * VDISP) begin
                    failures++;
                    $display("FAIL pops_frame1 got=%0d want %0d", pops_f1, HDISP * VDISP);
                end
            end
            if (c == FRAME + FIRST_POP + 1) begin
                checks++;
                if (rgb !== 24'd14400 || vga_blank !== 1'b1) begin
                    failures++;
                    $display("FAIL frame2_first rgb=%0d blank=%b want 14400 1", rgb, vga_blank);
                end
            end
            if (c >= UF_AT && c < UF_AT + 5) begin
                checks++;
                if (fifo_rreq !== 1'b0) begin
                    failures++;
                    $display("FAIL uf_rreq c=%0d rreq=%b want 0", c, fifo_rreq);
                end
            end
            if (c > UF_AT && c <= UF_AT + 5) begin
                checks++;
                if (vga_blank !== 1'b1 || rgb !== 24'd0) begin
                    failures++;
                    $display("FAIL uf_pixel c=%0d blank=%b rgb=%h want 1 0", c, vga_blank, rgb);
                end
            end
            if (c == UF_AT || c == UF_AT + 1 || c == RST_AT - 1) begin
                checks++;
                if (underflow !== (c != UF_AT)) begin
                    failures++;
                    $display("FAIL uf_flag c=%0d got=%b want %b", c, underflow, c != UF_AT);
                end
            end
            hs_prev = vga_hs;
            vs_prev = vga_vs;
            prev_rreq = fifo_rreq;
            prev_rdata = fifo_rdata;
        end
    endtask

    task automatic test_first_pop();
        checks++;
        if (first_pop != FIRST_POP) begin
            failures++;
            $display("FAIL first_pop got=%0d want %0d", first_pop, FIRST_POP);
        end
    endtask

    task automatic test_mid_frame_reset();
        @(posedge clk);
        #2;
        c++;
        checks++;
        if (vga_blank !== 1'b1 || rgb !== exp_px) begin
            failures++;
            $display("FAIL pre_reset blank=%b rgb=%h want 1 %h", vga_blank, rgb, exp_px);
        end
        exp_px = exp_px + 24'd1;
        nrst = 1'b0;
        #1;
        checks++;
        if (vga_hs !== 1'b1 || vga_vs !== 1'b1 || vga_blank !== 1'b0 || rgb !== 24'd0 ||
            underflow !== 1'b0 || fifo_rreq !== 1'b0) begin
            failures++;
            $display("FAIL async_reset hs=%b vs=%b blank=%b rgb=%h uf=%b rreq=%b (want 1 1 0 0 0 0)",
                     vga_hs, vga_vs, vga_blank, rgb, underflow, fifo_rreq);
        end
        @(posedge clk);
        #1;
        nrst = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (vga_hs !== 1'b1 || vga_vs !== 1'b1 || vga_blank !== 1'b0 || fifo_rreq !== 1'b0) begin
                failures++;
                $display("FAIL rewait cycle=%0d hs=%b vs=%b blank=%b rreq=%b (want 1 1 0 0)",
                         i, vga_hs, vga_vs, vga_blank, fifo_rreq);
            end
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_stream(RST_AT - 1);
        test_first_pop();
        test_mid_frame_reset();
        test_start();
        test_stream(FIRST_POP + 300);
        test_first_pop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
